// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM state encoding for the bit-serial add/subtract unit.
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        SA_IDLE = 2'b00,
        SA_RUN  = 2'b01,
        SA_DONE = 2'b10
    } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell: the only arithmetic element of the serial datapath.
module serial_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract engine: one full-adder cell, LSB-first, DATA_WIDTH cycles per op.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output V.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SnA,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  CO
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic                  V
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    sa_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_sh_q, a_sh_d;
    logic [DATA_WIDTH-1:0] b_sh_q, b_sh_d;
    logic [DATA_WIDTH-1:0] r_sh_q, r_sh_d;
    logic                  carry_q, carry_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic                  co_q, co_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic                  v_q, v_d;
`endif

    logic fa_s, fa_co;
    logic launch;
    logic last_bit;

    serial_adder_full_adder u_full_adder (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign launch   = START && (state_q == SA_IDLE || state_q == SA_DONE);
    assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        y_d     = y_q;
        co_d    = co_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        v_d     = v_q;
`endif

        case (state_q)
            SA_IDLE: if (launch) state_d = SA_RUN;
            SA_RUN: begin
                // The sum bit enters at the MSB so the result lands LSB-aligned after DATA_WIDTH shifts.
                r_sh_d  = DATA_WIDTH'({fa_s, r_sh_q} >> 1);
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    y_d     = DATA_WIDTH'({fa_s, r_sh_q} >> 1);
                    co_d    = fa_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    v_d     = carry_q ^ fa_co;
`endif
                    state_d = SA_DONE;
                end
            end
            SA_DONE: state_d = launch ? SA_RUN : SA_IDLE;
            default: state_d = SA_IDLE;
        endcase

        // Subtraction is A + ~B + 1: invert B and seed the carry with SnA.
        if (launch) begin
            a_sh_d  = A;
            b_sh_d  = SnA ? ~B : B;
            carry_d = SnA;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= SA_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            y_q     <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            y_q     <= y_d;
            co_q    <= co_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            v_q     <= v_d;
`endif
        end
    end

    assign BUSY = (state_q == SA_RUN);
    assign DONE = (state_q == SA_DONE);
    assign Y    = y_q;
    assign CO   = co_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at DATA_WIDTH=32.
module tb_serial_adder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        SnA = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        BUSY, DONE, CO;
    logic [31:0] Y;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic        V;
`endif

    int tests = 0;
    int fails = 0;

    serial_adder #(.DATA_WIDTH(32)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .SnA   (SnA),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Y     (Y),
        .CO    (CO)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .V     (V)
`endif
    );

    always #5 CLK = ~CLK;

    // Launches one op and returns the edge count to DONE (99 on timeout) and
    // how many RUN cycles showed BUSY low. Optionally pulses START mid-run.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sna,
                          input int inject_at, output int cyc, output int busy_bad);
        A = a; B = b; SnA = sna; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        cyc = 99;
        busy_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == inject_at) begin
                START = 1'b1; A = 32'hAAAAAAAA; B = 32'hAAAAAAAA; SnA = 1'b0;
            end
            @(posedge CLK); #1;
            if (i == inject_at) START = 1'b0;
            if (DONE) begin
                cyc = i;
                break;
            end
            if (!BUSY) busy_bad++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", DONE); end
        tests++; if (Y !== 32'h0) begin fails++; $display("FAIL reset_y got=%h exp=00000000", Y); end
        tests++; if (CO !== 1'b0) begin fails++; $display("FAIL reset_co got=%b exp=0", CO); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        tests++; if (V !== 1'b0) begin fails++; $display("FAIL reset_v got=%b exp=0", V); end
`endif
        RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_add();
        int cyc, bb;
        run_op(32'h5, 32'h3, 1'b0, 0, cyc, bb);
        tests++; if (cyc !== 32) begin fails++; $display("FAIL add_latency got=%0d exp=32", cyc); end
        tests++; if (bb !== 0) begin fails++; $display("FAIL add_busy_low_cycles got=%0d exp=0", bb); end
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL add_busy_at_done got=%b exp=0", BUSY); end
        tests++; if (Y !== 32'h8) begin fails++; $display("FAIL add_y got=%h exp=00000008", Y); end
        tests++; if (CO !== 1'b0) begin fails++; $display("FAIL add_co got=%b exp=0", CO); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        tests++; if (V !== 1'b0) begin fails++; $display("FAIL add_v got=%b exp=0", V); end
`endif
        @(posedge CLK); #1;
        tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL add_done_one_cycle got=%b exp=0", DONE); end
        tests++; if (Y !== 32'h8) begin fails++; $display("FAIL add_y_hold got=%h exp=00000008", Y); end
    endtask

    task automatic test_add_carry();
        int cyc, bb;
        run_op(32'hFFFFFFFF, 32'h1, 1'b0, 0, cyc, bb);
        tests++; if (cyc !== 32) begin fails++; $display("FAIL carry_latency got=%0d exp=32", cyc); end
        tests++; if (Y !== 32'h0) begin fails++; $display("FAIL carry_y got=%h exp=00000000", Y); end
        tests++; if (CO !== 1'b1) begin fails++; $display("FAIL carry_co got=%b exp=1", CO); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        tests++; if (V !== 1'b0) begin fails++; $display("FAIL carry_v got=%b exp=0", V); end
`endif
        @(posedge CLK); #1;
    endtask

    task automatic test_overflow();
        int cyc, bb;
        run_op(32'h7FFFFFFF, 32'h1, 1'b0, 0, cyc, bb);
        tests++; if (cyc !== 32) begin fails++; $display("FAIL ovf_latency got=%0d exp=32", cyc); end
        tests++; if (Y !== 32'h80000000) begin fails++; $display("FAIL ovf_y got=%h exp=80000000", Y); end
        tests++; if (CO !== 1'b0) begin fails++; $display("FAIL ovf_co got=%b exp=0", CO); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        tests++; if (V !== 1'b1) begin fails++; $display("FAIL ovf_v got=%b exp=1", V); end
`endif
        @(posedge CLK); #1;
    endtask

    task automatic test_subtract();
        int cyc, bb;
        run_op(32'h3, 32'h5, 1'b1, 0, cyc, bb);
        tests++; if (cyc !== 32) begin fails++; $display("FAIL sub_latency got=%0d exp=32", cyc); end
        tests++; if (Y !== 32'hFFFFFFFE) begin fails++; $display("FAIL sub_y got=%h exp=fffffffe", Y); end
        tests++; if (CO !== 1'b0) begin fails++; $display("FAIL sub_co got=%b exp=0", CO); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        tests++; if (V !== 1'b0) begin fails++; $display("FAIL sub_v got=%b exp=0", V); end
`endif
        run_op(32'h9, 32'h4, 1'b1, 0, cyc, bb);
        tests++; if (Y !== 32'h5) begin fails++; $display("FAIL sub2_y got=%h exp=00000005", Y); end
        tests++; if (CO !== 1'b1) begin fails++; $display("FAIL sub2_co got=%b exp=1", CO); end
        @(posedge CLK); #1;
    endtask

    task automatic test_busy_protect();
        int cyc, bb;
        run_op(32'h5, 32'h3, 1'b0, 10, cyc, bb);
        tests++; if (cyc !== 32) begin fails++; $display("FAIL busy_latency got=%0d exp=32", cyc); end
        tests++; if (Y !== 32'h8) begin fails++; $display("FAIL busy_y got=%h exp=00000008", Y); end
        @(posedge CLK); #1;
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL busy_no_relaunch got=%b exp=0", BUSY); end
    endtask

    task automatic test_back_to_back();
        int cyc, bb;
        run_op(32'h5, 32'h3, 1'b0, 0, cyc, bb);
        tests++; if (Y !== 32'h8) begin fails++; $display("FAIL b2b_first_y got=%h exp=00000008", Y); end
        // Called in the DONE cycle, so the next edge accepts START from DONE.
        run_op(32'h1, 32'h1, 1'b0, 0, cyc, bb);
        tests++; if (cyc !== 32) begin fails++; $display("FAIL b2b_latency got=%0d exp=32", cyc); end
        tests++; if (bb !== 0) begin fails++; $display("FAIL b2b_busy_low_cycles got=%0d exp=0", bb); end
        tests++; if (Y !== 32'h2) begin fails++; $display("FAIL b2b_y got=%h exp=00000002", Y); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_abort();
        int done_seen;
        A = 32'h5; B = 32'h3; SnA = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL abort_busy_before got=%b exp=1", BUSY); end
        RST = 1'b0;
        #1;
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", BUSY); end
        tests++; if (Y !== 32'h0) begin fails++; $display("FAIL abort_y got=%h exp=00000000", Y); end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            if (DONE) done_seen++;
        end
        RST = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) done_seen++;
        end
        tests++; if (done_seen !== 0) begin fails++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_carry();
        test_overflow();
        test_subtract();
        test_busy_protect();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
